// File: rtl/p_tally.sv
// p_tally: two-stage valid/ready pipeline that decodes admitted thermometer codes
// to length/polarity and keeps saturating admit/reject statistics.
module p_tally #(
    parameter int W     = 16,
    parameter int CNT_W = 16,
    localparam int LW   = $clog2(W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_vld,
    output logic             o_in_rdy,
    input  logic [W-1:0]     i_in_x,
    input  logic             i_in_is_unary,
    output logic             o_out_vld,
    input  logic             i_out_rdy,
    output logic [LW-1:0]    o_out_len,
    output logic             o_out_inv,
    output logic             o_out_err,
    input  logic             i_clr_cnt,
    output logic [CNT_W-1:0] o_admit_cnt,
    output logic [CNT_W-1:0] o_reject_cnt
);

    // Handshakes: a beat moves when valid and ready are both high on a rising
    // edge; valid never depends on ready, and a stalled beat holds its payload.
    logic             s1_vld_q, s1_vld_d;
    logic [W-1:0]     s1_x_q, s1_x_d;
    logic             s1_unary_q, s1_unary_d;
    logic             s2_vld_q, s2_vld_d;
    logic [LW-1:0]    len_q, len_d;
    logic             inv_q, inv_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] admit_q, admit_d;
    logic [CNT_W-1:0] reject_q, reject_d;

    logic          s2_adv, s1_adv, in_hs, out_hs;
    logic [W-1:0]  pc_src;
    logic [LW:0]   pc;
    logic [LW-1:0] dec_len;
    logic          dec_inv, dec_err;

    assign s2_adv   = !s2_vld_q || i_out_rdy;
    assign s1_adv   = s1_vld_q && s2_adv;
    assign o_in_rdy = !s1_vld_q || s1_adv;
    assign in_hs    = i_in_vld && o_in_rdy;
    assign out_hs   = s2_vld_q && i_out_rdy;

    // Decode trusts the upstream admission flag; a rejected beat carries err only.
    always_comb begin
        dec_inv = s1_x_q[W-1];
        pc_src  = dec_inv ? ~s1_x_q : s1_x_q;
        pc      = '0;
        for (int i = 0; i < W; i++) begin
            pc = pc + {{LW{1'b0}}, pc_src[i]};
        end
        dec_len = pc[LW-1:0];
        dec_err = 1'b0;
        if (!s1_unary_q) begin
            dec_err = 1'b1;
            dec_len = '0;
            dec_inv = 1'b0;
        end
    end

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_x_d     = s1_x_q;
        s1_unary_d = s1_unary_q;
        s2_vld_d   = s2_vld_q;
        len_d      = len_q;
        inv_d      = inv_q;
        err_d      = err_q;
        admit_d    = admit_q;
        reject_d   = reject_q;

        if (in_hs) begin
            s1_vld_d   = 1'b1;
            s1_x_d     = i_in_x;
            s1_unary_d = i_in_is_unary;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                len_d = dec_len;
                inv_d = dec_inv;
                err_d = dec_err;
            end
        end

        // Clear beats a coincident delivery; counters stick at all-ones.
        if (i_clr_cnt) begin
            admit_d  = '0;
            reject_d = '0;
        end else if (out_hs) begin
            if (!err_q && (admit_q != {CNT_W{1'b1}})) begin
                admit_d = admit_q + 1'b1;
            end
            if (err_q && (reject_q != {CNT_W{1'b1}})) begin
                reject_d = reject_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_unary_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            len_q      <= '0;
            inv_q      <= 1'b0;
            err_q      <= 1'b0;
            admit_q    <= '0;
            reject_q   <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_x_q     <= s1_x_d;
            s1_unary_q <= s1_unary_d;
            s2_vld_q   <= s2_vld_d;
            len_q      <= len_d;
            inv_q      <= inv_d;
            err_q      <= err_d;
            admit_q    <= admit_d;
            reject_q   <= reject_d;
        end
    end

    assign o_out_vld    = s2_vld_q;
    assign o_out_len    = len_q;
    assign o_out_inv    = inv_q;
    assign o_out_err    = err_q;
    assign o_admit_cnt  = admit_q;
    assign o_reject_cnt = reject_q;

endmodule

// File: tb/tb_p_tally.sv
// Bench for p_tally: directed scenarios plus randomized traffic checked by a
// scoreboard fed from a specification-level decode model.
module tb_p_tally;
    localparam int W     = 16;
    localparam int CNT_W = 4;
    localparam int LW    = 4;
    localparam int EW    = LW + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_vld;
    logic             in_rdy;
    logic [W-1:0]     in_x;
    logic             in_unary;
    logic             out_vld;
    logic             out_rdy;
    logic [LW-1:0]    out_len;
    logic             out_inv;
    logic             out_err;
    logic             clr;
    logic [CNT_W-1:0] admit_cnt;
    logic [CNT_W-1:0] reject_cnt;

    always #5 clk = ~clk;

    p_tally #(.W(W), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_vld      (in_vld),
        .o_in_rdy      (in_rdy),
        .i_in_x        (in_x),
        .i_in_is_unary (in_unary),
        .o_out_vld     (out_vld),
        .i_out_rdy     (out_rdy),
        .o_out_len     (out_len),
        .o_out_inv     (out_inv),
        .o_out_err     (out_err),
        .i_clr_cnt     (clr),
        .o_admit_cnt   (admit_cnt),
        .o_reject_cnt  (reject_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference decode: {err, inv, len} straight from the rules.
    function automatic logic [EW-1:0] ref_decode(input logic [W-1:0] x, input logic u);
        logic        inv;
        logic [31:0] n;
        if (!u) return {1'b1, 1'b0, {LW{1'b0}}};
        inv = x[W-1];
        n   = $countones(inv ? ~x : x);
        return {1'b0, inv, n[LW-1:0]};
    endfunction

    // Scoreboard and counter model.
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    exp_beat;
    logic [CNT_W-1:0] m_adm, m_rej;
    logic             prev_stall;
    logic [EW-1:0]    prev_out;
    logic             popped;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_adm      = '0;
            m_rej      = '0;
            prev_stall = 1'b0;
        end else begin
            check("admit_cnt", 32'(admit_cnt), 32'(m_adm));
            check("reject_cnt", 32'(reject_cnt), 32'(m_rej));
            if (prev_stall) begin
                check("stall_vld", 32'(out_vld), 32'd1);
                check("stall_data", 32'({out_err, out_inv, out_len}), 32'(prev_out));
            end
            popped = 1'b0;
            if (out_vld && out_rdy) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    popped   = 1'b1;
                    check("out_beat", 32'({out_err, out_inv, out_len}), 32'(exp_beat));
                end
            end
            if (clr) begin
                m_adm = '0;
                m_rej = '0;
            end else if (popped) begin
                if (exp_beat[EW-1]) begin
                    if (m_rej != '1) m_rej = m_rej + 1'b1;
                end else begin
                    if (m_adm != '1) m_adm = m_adm + 1'b1;
                end
            end
            if (in_vld && in_rdy) exp_q.push_back(ref_decode(in_x, in_unary));
            prev_stall = out_vld && !out_rdy;
            prev_out   = {out_err, out_inv, out_len};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_expect(input string tag, input logic [W-1:0] x, input logic u,
                               input logic [LW-1:0] len, input logic inv, input logic err);
        step();
        in_vld = 1'b1; in_x = x; in_unary = u;
        step();
        in_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_vld) break;
        end
        check({tag, "_vld"}, 32'(out_vld), 32'd1);
        check({tag, "_len"}, 32'(out_len), 32'(len));
        check({tag, "_inv"}, 32'(out_inv), 32'(inv));
        check({tag, "_err"}, 32'(out_err), 32'(err));
    endtask

    logic [W-1:0] therm;
    int           tlen;

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_x = '0; in_unary = 1'b0; out_rdy = 1'b1; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_len", 32'(out_len), 32'd0);
        check("rst_inv", 32'(out_inv), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_adm", 32'(admit_cnt), 32'd0);
        check("rst_rej", 32'(reject_cnt), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);

        // Latency: accept in cycle N, output valid in N+2.
        step();
        in_vld = 1'b1; in_x = 16'h0007; in_unary = 1'b1;
        @(negedge clk);
        check("t1_in_rdy", 32'(in_rdy), 32'd1);
        step();
        in_vld = 1'b0;
        @(negedge clk);
        check("t1_vld_n1", 32'(out_vld), 32'd0);
        step();
        @(negedge clk);
        check("t1_vld_n2", 32'(out_vld), 32'd1);
        check("t1_len", 32'(out_len), 32'd3);
        check("t1_inv", 32'(out_inv), 32'd0);
        check("t1_err", 32'(out_err), 32'd0);
        step();
        @(negedge clk);
        check("t1_adm", 32'(admit_cnt), 32'd1);

        // Polarity, top-bit-only and rejected beats.
        step(); clr = 1'b1; step(); clr = 1'b0;
        send_expect("t2a", 16'hFFF0, 1'b1, 4'd4, 1'b1, 1'b0);
        send_expect("t2b", 16'h8000, 1'b1, 4'd15, 1'b1, 1'b0);
        send_expect("t3", 16'h0005, 1'b0, 4'd0, 1'b0, 1'b1);
        step();
        @(negedge clk);
        check("t3_adm", 32'(admit_cnt), 32'd2);
        check("t3_rej", 32'(reject_cnt), 32'd1);

        // Backpressure: two beats fill the pipe, third waits, then drain in order.
        step();
        out_rdy = 1'b0; in_vld = 1'b1; in_x = 16'h0001; in_unary = 1'b1;
        @(negedge clk); check("t4_rdy_a", 32'(in_rdy), 32'd1);
        step(); in_x = 16'h0003;
        @(negedge clk); check("t4_rdy_b", 32'(in_rdy), 32'd1);
        step(); in_x = 16'hFFFE;
        @(negedge clk);
        check("t4_rdy_c", 32'(in_rdy), 32'd0);
        check("t4_hold_vld", 32'(out_vld), 32'd1);
        check("t4_hold_len", 32'(out_len), 32'd1);
        step();
        @(negedge clk);
        check("t4_rdy_c2", 32'(in_rdy), 32'd0);
        step(); out_rdy = 1'b1;
        @(negedge clk);
        check("t4_rdy_rel", 32'(in_rdy), 32'd1);
        check("t4_a_vld", 32'(out_vld), 32'd1);
        check("t4_a_len", 32'(out_len), 32'd1);
        step(); in_vld = 1'b0;
        @(negedge clk);
        check("t4_b_vld", 32'(out_vld), 32'd1);
        check("t4_b_len", 32'(out_len), 32'd2);
        step();
        @(negedge clk);
        check("t4_c_vld", 32'(out_vld), 32'd1);
        check("t4_c_len", 32'(out_len), 32'd1);
        check("t4_c_inv", 32'(out_inv), 32'd1);
        step();
        @(negedge clk);
        check("t4_empty", 32'(out_vld), 32'd0);

        // Saturation with a 4-bit counter, then clear racing a delivery.
        clr = 1'b1; step(); clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_vld = 1'b1; in_x = 16'h00FF; in_unary = 1'b1;
            step();
        end
        in_vld = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("t5_sat", 32'(admit_cnt), 32'd15);
        step();
        in_vld = 1'b1; in_x = 16'h000F; in_unary = 1'b1;
        step(); in_vld = 1'b0;
        step(); clr = 1'b1;
        @(negedge clk);
        check("t5_clr_hs", 32'(out_vld && out_rdy), 32'd1);
        step(); clr = 1'b0;
        @(negedge clk);
        check("t5_clr_adm", 32'(admit_cnt), 32'd0);

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            step();
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 9) < 7);
            clr     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) != 0) begin
                tlen  = $urandom_range(0, W - 1);
                therm = (16'h1 << tlen) - 16'h1;
                if ($urandom_range(0, 1) == 1) therm = ~therm;
                in_x = therm; in_unary = 1'b1;
            end else begin
                in_x = 16'($urandom); in_unary = 1'($urandom_range(0, 1));
            end
        end
        step();
        in_vld = 1'b0; out_rdy = 1'b1; clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full.
        step();
        out_rdy = 1'b0; in_vld = 1'b1; in_x = 16'h0003; in_unary = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("t6_full_rdy", 32'(in_rdy), 32'd0);
        check("t6_full_vld", 32'(out_vld), 32'd1);
        step(); rst = 1'b1; in_vld = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        check("t6_vld", 32'(out_vld), 32'd0);
        check("t6_adm", 32'(admit_cnt), 32'd0);
        check("t6_rej", 32'(reject_cnt), 32'd0);
        check("t6_in_rdy", 32'(in_rdy), 32'd1);
        step(); out_rdy = 1'b1;
        @(negedge clk);
        check("t6_no_ghost", 32'(out_vld), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
